// File: rtl/snn_cluster_pkg.sv
// Shared types and constants for the neuron cluster scan logic.
// Holds the fire-scheduler FSM states, leak mode encodings and default-width potential limits.
package snn_cluster_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_EVAL,
        S_FIRE,
        S_WRITE,
        S_DONE
    } sche_state_t;

    localparam logic [1:0] LEAK_NONE  = 2'd0;
    localparam logic [1:0] LEAK_SUB   = 2'd1;
    localparam logic [1:0] LEAK_SHIFT = 2'd2;

    localparam int POT_WIDTH_DEF = 32;
    localparam logic [POT_WIDTH_DEF-1:0] POT_MAX = {1'b0, {(POT_WIDTH_DEF-1){1'b1}}};
    localparam logic [POT_WIDTH_DEF-1:0] POT_MIN = {1'b1, {(POT_WIDTH_DEF-1){1'b0}}};

endpackage

// File: rtl/lif_update.sv
// Single-channel leak (none / saturating subtract / arithmetic shift) and signed threshold compare.
// Purely combinational, no latency and no handshake.
module lif_update
    import snn_cluster_pkg::*;
#(
    parameter int POTENTIAL_WIDTH = 32
) (
    input  logic [POTENTIAL_WIDTH-1:0] pot,
    input  logic [1:0]                 leak_mode,
    input  logic [POTENTIAL_WIDTH-1:0] leak_value,
    input  logic [POTENTIAL_WIDTH-1:0] threhold,
    output logic [POTENTIAL_WIDTH-1:0] v,
    output logic                       fire
);

    localparam int W = POTENTIAL_WIDTH;
    localparam logic [W-1:0] V_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] V_MIN = {1'b1, {(W-1){1'b0}}};

    logic [W:0] diff;

    always_comb begin
        // One guard bit: overflow shows up as the two top bits disagreeing.
        diff = {pot[W-1], pot} - {leak_value[W-1], leak_value};
        v    = pot;
        case (leak_mode)
            LEAK_NONE:  v = pot;
            LEAK_SUB: begin
                if (diff[W] != diff[W-1]) v = diff[W] ? V_MIN : V_MAX;
                else                      v = diff[W-1:0];
            end
            LEAK_SHIFT: v = $signed(pot) >>> leak_value[4:0];
            default:    v = pot;
        endcase
        fire = $signed(v) >= $signed(threhold);
    end

endmodule

// File: rtl/lif_fire_scheduler.sv
// Scan-phase fire scheduler: leaks, thresholds and writes back every neuron in the potential memory.
// MAX_KERNEL_NUM+3 cycles per spike-free word; each spike stalls in FIRE until post_grant.
module lif_fire_scheduler
    import snn_cluster_pkg::*;
#(
    parameter int POTENTIAL_WIDTH = 32,
    parameter int POTENTIAL_DEPTH = 16,
    parameter int MAX_KERNEL_NUM  = 16,
    parameter int POST_WIDTH      = 32,
    parameter int TS_WIDTH        = 8
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start_sche,
    input  logic [15:0]                                output_neuron_num,
    input  logic [POTENTIAL_WIDTH-1:0]                 threhold,
    input  logic [POTENTIAL_WIDTH-1:0]                 rest_value,
    input  logic [1:0]                                 leak_mode,
    input  logic [POTENTIAL_WIDTH-1:0]                 leak_value,
    input  logic [TS_WIDTH-1:0]                        timestamp,
    input  logic [POST_WIDTH-1:0]                      post_base,
    output logic                                       pot_ren,
    output logic [$clog2(POTENTIAL_DEPTH)-1:0]         pot_raddr,
    input  logic [POTENTIAL_WIDTH*MAX_KERNEL_NUM-1:0]  pot_rdata,
    output logic                                       pot_wen,
    output logic [$clog2(POTENTIAL_DEPTH)-1:0]         pot_waddr,
    output logic [POTENTIAL_WIDTH*MAX_KERNEL_NUM-1:0]  pot_wdata,
    output logic                                       post_req,
    input  logic                                       post_grant,
    output logic [POST_WIDTH-1:0]                      post_waddr,
    output logic [POST_WIDTH-1:0]                      post_wdata,
    output logic                                       busy,
    output logic                                       finish_sche,
    output logic [15:0]                                spike_count
);

    localparam int W     = POTENTIAL_WIDTH;
    localparam int AW    = $clog2(POTENTIAL_DEPTH);
    localparam int CW    = $clog2(MAX_KERNEL_NUM);
    localparam int TOTAL = POTENTIAL_DEPTH * MAX_KERNEL_NUM;
    localparam logic [CW-1:0] LAST_CH = CW'(MAX_KERNEL_NUM - 1);

    sche_state_t state, state_nxt;

    logic [15:0]           n_q, n_clamped, id, last_word;
    logic [W-1:0]          thr_q, rest_q, leak_q, v;
    logic [1:0]            mode_q;
    logic [TS_WIDTH-1:0]   ts_q;
    logic [POST_WIDTH-1:0] base_q;
    logic [AW-1:0]         word_q;
    logic [CW-1:0]         chan_q;
    logic [W-1:0]          buf_q [MAX_KERNEL_NUM];
    logic                  fire, skip, last_ch;

    // Channel count is a power of two, so the neuron id is just word and channel concatenated.
    assign id        = 16'({word_q, chan_q});
    assign last_word = (n_q - 16'd1) >> CW;
    assign skip      = id >= n_q;
    assign last_ch   = chan_q == LAST_CH;
    assign pot_raddr = word_q;
    assign pot_waddr = word_q;

    always_comb begin
        n_clamped = output_neuron_num;
        if (32'(output_neuron_num) > TOTAL) n_clamped = 16'(TOTAL);
    end

    lif_update #(.POTENTIAL_WIDTH(W)) u_lif (
        .pot        (buf_q[chan_q]),
        .leak_mode  (mode_q),
        .leak_value (leak_q),
        .threhold   (thr_q),
        .v          (v),
        .fire       (fire)
    );

    for (genvar k = 0; k < MAX_KERNEL_NUM; k++) begin : g_pack
        assign pot_wdata[k*W +: W] = buf_q[k];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        pot_ren     = 1'b0;
        pot_wen     = 1'b0;
        post_req    = 1'b0;
        finish_sche = 1'b0;
        busy        = (state != S_IDLE) && (state != S_DONE);
        case (state)
            S_IDLE:  if (start_sche) state_nxt = (output_neuron_num == 16'd0) ? S_DONE : S_READ;
            S_READ: begin
                pot_ren   = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT:  state_nxt = S_EVAL;
            S_EVAL: begin
                if (!skip && fire) state_nxt = S_FIRE;
                else if (last_ch)  state_nxt = S_WRITE;
            end
            S_FIRE: begin
                post_req = 1'b1;
                if (post_grant) state_nxt = last_ch ? S_WRITE : S_EVAL;
            end
            S_WRITE: begin
                pot_wen   = 1'b1;
                state_nxt = (16'(word_q) == last_word) ? S_DONE : S_READ;
            end
            S_DONE: begin
                finish_sche = 1'b1;
                state_nxt   = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_q         <= '0;
            thr_q       <= '0;
            rest_q      <= '0;
            leak_q      <= '0;
            mode_q      <= '0;
            ts_q        <= '0;
            base_q      <= '0;
            word_q      <= '0;
            chan_q      <= '0;
            post_waddr  <= '0;
            post_wdata  <= '0;
            spike_count <= '0;
            for (int k = 0; k < MAX_KERNEL_NUM; k++) buf_q[k] <= '0;
        end else begin
            case (state)
                S_IDLE: if (start_sche) begin
                    n_q         <= n_clamped;
                    thr_q       <= threhold;
                    rest_q      <= rest_value;
                    leak_q      <= leak_value;
                    mode_q      <= leak_mode;
                    ts_q        <= timestamp;
                    base_q      <= post_base;
                    word_q      <= '0;
                    chan_q      <= '0;
                    spike_count <= '0;
                end
                S_WAIT: begin
                    for (int k = 0; k < MAX_KERNEL_NUM; k++) buf_q[k] <= pot_rdata[k*W +: W];
                    chan_q <= '0;
                end
                S_EVAL: begin
                    if (skip || !fire) begin
                        if (!skip) buf_q[chan_q] <= v;
                        chan_q <= chan_q + CW'(1);
                    end else begin
                        // Event fields are registered here so they stay frozen through FIRE.
                        post_waddr <= base_q + POST_WIDTH'(id);
                        post_wdata <= {ts_q, (POST_WIDTH-TS_WIDTH)'(id)};
                    end
                end
                S_FIRE: if (post_grant) begin
                    buf_q[chan_q] <= rest_q;
                    chan_q        <= chan_q + CW'(1);
                    if (spike_count != 16'hFFFF) spike_count <= spike_count + 16'd1;
                end
                S_WRITE: if (16'(word_q) != last_word) word_q <= word_q + AW'(1);
                default: ;
            endcase
        end
    end

endmodule
